// File: rtl/di_pingpong_sched_pkg.sv
// ============================================================================
// Module  : di_pingpong_sched_pkg
// Brief   : Shared stream type codes, bank/FSM encodings and length width.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package di_pingpong_sched_pkg;

    localparam int DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] c_DTYPE_FRAME_START = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] c_DTYPE_FRAME_END   = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK    = 4'hC;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_READY   = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    localparam logic [1:0] c_WIDLE    = 2'd0;
    localparam logic [1:0] c_WCAPTURE = 2'd1;
    localparam logic [1:0] c_WDROP    = 2'd2;

    localparam logic [1:0] c_RIDLE    = 2'd0;
    localparam logic [1:0] c_READING  = 2'd1;
    localparam logic [1:0] c_RDONE    = 2'd2;

    // A bank length counts words, so it needs one bit more than an address.
    function automatic int len_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/di_bank_tracker.sv
// ============================================================================
// Module  : di_bank_tracker
// Brief   : Per-bank ownership state, stored length and age; bank pickers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module di_bank_tracker
    import di_pingpong_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_claim,
    input  logic                  i_wr_claim_idx,
    input  logic                  i_wr_commit,
    input  logic                  i_wr_commit_idx,
    input  logic [ADDR_WIDTH:0]   i_wr_commit_len,
    input  logic                  i_rd_claim,
    input  logic                  i_rd_claim_idx,
    input  logic                  i_rd_release,
    input  logic                  i_rd_release_idx,
    input  logic                  i_excl_valid,
    input  logic                  i_excl_idx,
    output logic                  o_empty_valid,
    output logic                  o_empty_idx,
    output logic                  o_ready_valid,
    output logic                  o_ready_idx,
    output logic [ADDR_WIDTH:0]   o_ready_len,
    output logic                  o_ovr_valid,
    output logic                  o_ovr_idx
);

    logic [1:0]          w_is_empty;
    logic [1:0]          w_is_ready;
    logic [1:0]          w_age;
    logic [1:0]          w_cand;
    logic [ADDR_WIDTH:0] w_len [2];

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            bank_state_t         r_state;
            logic [ADDR_WIDTH:0] r_len;
            logic                r_age;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= BANK_EMPTY;
                    r_len   <= '0;
                    r_age   <= 1'b0;
                end else begin
                    if (i_wr_claim && i_wr_claim_idx == 1'(b))
                        r_state <= BANK_FILLING;
                    if (i_wr_commit && i_wr_commit_idx == 1'(b)) begin
                        r_state <= BANK_READY;
                        r_len   <= i_wr_commit_len;
                    end
                    // Age 1 marks the most recently committed bank.
                    if (i_wr_commit)
                        r_age <= (i_wr_commit_idx == 1'(b));
                    if (i_rd_claim && i_rd_claim_idx == 1'(b))
                        r_state <= BANK_READING;
                    if (i_rd_release && i_rd_release_idx == 1'(b))
                        r_state <= BANK_EMPTY;
                end
            end

            assign w_is_empty[b] = (r_state == BANK_EMPTY);
            assign w_is_ready[b] = (r_state == BANK_READY);
            assign w_age[b]      = r_age;
            assign w_len[b]      = r_len;
        end
    endgenerate

    assign o_empty_valid = |w_is_empty;
    assign o_empty_idx   = ~w_is_empty[0];

    assign o_ready_valid = |w_is_ready;
    assign o_ready_idx   = (&w_is_ready) ? w_age[0] : ~w_is_ready[0];
    assign o_ready_len   = w_len[o_ready_idx];

    // Overwrite candidate skips the bank the reader claims this same cycle.
    assign w_cand      = w_is_ready & ~(i_excl_valid ? (2'b01 << i_excl_idx) : 2'b00);
    assign o_ovr_valid = |w_cand;
    assign o_ovr_idx   = (&w_cand) ? w_age[0] : ~w_cand[0];

endmodule

`default_nettype wire

// File: rtl/di_pingpong_sched.sv
// ============================================================================
// Module  : di_pingpong_sched
// Brief   : Two-bank ping-pong scheduler between pixel stream and DI reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module di_pingpong_sched
    import di_pingpong_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   drop_old,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic                   di_read_mode,
    input  logic                   di_read,
    output logic                   we,
    output logic                   wsel,
    output logic [ADDR_WIDTH-1:0]  waddr,
    output logic                   wphase,
    output logic                   rsel,
    output logic [ADDR_WIDTH-1:0]  raddr,
    output logic                   di_read_rdy,
    output logic [ADDR_WIDTH:0]    rlen,
    output logic [CNT_WIDTH-1:0]   frames_dropped,
    output logic                   frame_abort,
    output logic                   wovf
);

    localparam int LEN_W = len_width(ADDR_WIDTH);

    logic             w_clr, w_sof, w_eof, w_pix, w_full;
    logic [1:0]       r_wstate, w_wstate_nxt, r_rstate, w_rstate_nxt;
    logic [LEN_W-1:0] r_wcnt, w_wcnt_nxt, r_rcnt, w_rcnt_nxt, w_rcnt_inc;
    logic             r_wpend, w_wpend_nxt;
    logic             w_we_nxt, w_wsel_nxt, w_wphase_nxt, w_abort_nxt;
    logic             w_wovf_set, w_drop_inc;
    logic [ADDR_WIDTH-1:0] w_waddr_nxt;
    logic             w_wr_claim, w_wr_claim_idx, w_wr_commit;
    logic [LEN_W-1:0] w_wr_commit_len;
    logic             w_rd_claim, w_rd_release, w_rsel_nxt, w_rdy_nxt;
    logic [LEN_W-1:0] w_rlen_nxt;
    logic             w_empty_valid, w_empty_idx, w_ready_valid, w_ready_idx;
    logic             w_ovr_valid, w_ovr_idx;
    logic [LEN_W-1:0] w_ready_len;

    assign w_clr      = reset | ~enable;
    assign w_sof      = dvi && (dtypei == c_DTYPE_FRAME_START);
    assign w_eof      = dvi && (dtypei == c_DTYPE_FRAME_END);
    assign w_pix      = dvi && !w_sof && !w_eof && |(dtypei & DTYPE_PIXEL_MASK);
    assign w_full     = r_wcnt[ADDR_WIDTH];
    assign w_rcnt_inc = r_rcnt + LEN_W'(1);

    di_bank_tracker #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank_tracker (
        .clk              (clk),
        .rst              (w_clr),
        .i_wr_claim       (w_wr_claim),
        .i_wr_claim_idx   (w_wr_claim_idx),
        .i_wr_commit      (w_wr_commit),
        .i_wr_commit_idx  (wsel),
        .i_wr_commit_len  (w_wr_commit_len),
        .i_rd_claim       (w_rd_claim),
        .i_rd_claim_idx   (w_ready_idx),
        .i_rd_release     (w_rd_release),
        .i_rd_release_idx (rsel),
        .i_excl_valid     (w_rd_claim),
        .i_excl_idx       (w_ready_idx),
        .o_empty_valid    (w_empty_valid),
        .o_empty_idx      (w_empty_idx),
        .o_ready_valid    (w_ready_valid),
        .o_ready_idx      (w_ready_idx),
        .o_ready_len      (w_ready_len),
        .o_ovr_valid      (w_ovr_valid),
        .o_ovr_idx        (w_ovr_idx)
    );

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wstate <= c_WIDLE;
            r_rstate <= c_RIDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_rstate_nxt = r_rstate;
        case (r_wstate)
            c_WIDLE:    if (w_sof) w_wstate_nxt = (w_empty_valid || (drop_old && w_ovr_valid))
                                                  ? c_WCAPTURE : c_WDROP;
            c_WCAPTURE: if (w_eof) w_wstate_nxt = c_WIDLE;
            c_WDROP:    if (w_eof) w_wstate_nxt = c_WIDLE;
            default:    w_wstate_nxt = c_WIDLE;
        endcase
        case (r_rstate)
            c_RIDLE:   if (di_read_mode && w_ready_valid)
                           w_rstate_nxt = (w_ready_len != '0) ? c_READING : c_RDONE;
            c_READING: if (!di_read_mode) w_rstate_nxt = c_RIDLE;
                       else if (di_read && di_read_rdy && w_rcnt_inc == rlen) w_rstate_nxt = c_RDONE;
            c_RDONE:   if (!di_read_mode) w_rstate_nxt = c_RIDLE;
            default:   w_rstate_nxt = c_RIDLE;
        endcase
    end

    always_comb begin
        w_we_nxt = 1'b0;  w_wsel_nxt = wsel;  w_waddr_nxt = waddr;  w_wphase_nxt = wphase;
        w_wcnt_nxt = r_wcnt;  w_wpend_nxt = r_wpend;  w_abort_nxt = 1'b0;
        w_wovf_set = 1'b0;  w_drop_inc = 1'b0;
        w_wr_claim = 1'b0;  w_wr_claim_idx = w_empty_idx;
        w_wr_commit = 1'b0; w_wr_commit_len = r_wcnt;
        case (r_wstate)
            c_WIDLE: if (w_sof) begin
                w_wcnt_nxt = '0;  w_wpend_nxt = 1'b0;  w_waddr_nxt = '0;  w_wphase_nxt = 1'b0;
                if (w_empty_valid) begin
                    w_wr_claim = 1'b1;  w_wr_claim_idx = w_empty_idx;  w_wsel_nxt = w_empty_idx;
                end else if (drop_old && w_ovr_valid) begin
                    w_wr_claim = 1'b1;  w_wr_claim_idx = w_ovr_idx;    w_wsel_nxt = w_ovr_idx;
                    w_drop_inc = 1'b1;
                end else begin
                    w_drop_inc = 1'b1;
                end
            end
            c_WCAPTURE: begin
                if (w_sof) begin
                    w_abort_nxt = 1'b1;  w_wcnt_nxt = '0;  w_wpend_nxt = 1'b0;
                    w_waddr_nxt = '0;    w_wphase_nxt = 1'b0;
                end else if (w_eof) begin
                    w_wr_commit = 1'b1;  w_wpend_nxt = 1'b0;
                    // An odd pixel count leaves a half word that is flushed here.
                    if (r_wpend) begin
                        if (w_full) begin
                            w_wovf_set = 1'b1;
                        end else begin
                            w_we_nxt = 1'b1;  w_wphase_nxt = 1'b1;
                            w_waddr_nxt = r_wcnt[ADDR_WIDTH-1:0];
                            w_wr_commit_len = r_wcnt + LEN_W'(1);
                        end
                    end
                end else if (w_pix) begin
                    if (w_full) begin
                        w_wovf_set = 1'b1;
                    end else begin
                        w_waddr_nxt  = r_wcnt[ADDR_WIDTH-1:0];
                        w_wphase_nxt = r_wpend;
                        w_wpend_nxt  = ~r_wpend;
                        if (r_wpend) begin
                            w_we_nxt   = 1'b1;
                            w_wcnt_nxt = r_wcnt + LEN_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rcnt_nxt = r_rcnt;  w_rsel_nxt = rsel;  w_rlen_nxt = rlen;  w_rdy_nxt = di_read_rdy;
        w_rd_claim = 1'b0;    w_rd_release = 1'b0;
        case (r_rstate)
            c_RIDLE: if (di_read_mode && w_ready_valid) begin
                w_rd_claim = 1'b1;  w_rsel_nxt = w_ready_idx;  w_rcnt_nxt = '0;
                w_rlen_nxt = w_ready_len;  w_rdy_nxt = (w_ready_len != '0);
            end
            c_READING: begin
                if (!di_read_mode) begin
                    w_rd_release = 1'b1;  w_rcnt_nxt = '0;  w_rdy_nxt = 1'b0;
                end else if (di_read && di_read_rdy) begin
                    w_rcnt_nxt = w_rcnt_inc;  w_rdy_nxt = (w_rcnt_inc < rlen);
                end
            end
            c_RDONE: if (!di_read_mode) begin
                w_rd_release = 1'b1;  w_rcnt_nxt = '0;  w_rdy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            we <= 1'b0;  wsel <= 1'b0;  waddr <= '0;  wphase <= 1'b0;
            frame_abort <= 1'b0;  wovf <= 1'b0;  frames_dropped <= '0;
            rsel <= 1'b0;  raddr <= '0;  rlen <= '0;  di_read_rdy <= 1'b0;
            r_wcnt <= '0;  r_wpend <= 1'b0;  r_rcnt <= '0;
        end else begin
            we          <= w_we_nxt;
            wsel        <= w_wsel_nxt;
            waddr       <= w_waddr_nxt;
            wphase      <= w_wphase_nxt;
            frame_abort <= w_abort_nxt;
            wovf        <= wovf | w_wovf_set;
            if (w_drop_inc && frames_dropped != '1)
                frames_dropped <= frames_dropped + CNT_WIDTH'(1);
            r_wcnt      <= w_wcnt_nxt;
            r_wpend     <= w_wpend_nxt;
            rsel        <= w_rsel_nxt;
            rlen        <= w_rlen_nxt;
            di_read_rdy <= w_rdy_nxt;
            r_rcnt      <= w_rcnt_nxt;
            raddr       <= w_rcnt_nxt[ADDR_WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_di_pingpong_sched.sv
// ============================================================================
// Module  : tb_di_pingpong_sched
// Brief   : Directed self-checking bench with a write-strobe scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_di_pingpong_sched;
    import di_pingpong_sched_pkg::*;

    localparam int AW = 3;
    localparam int CW = 16;

    logic                   clk, reset, enable, drop_old, dvi, di_read_mode, di_read;
    logic [DTYPE_WIDTH-1:0] dtypei;
    logic                   we, wsel, wphase, rsel, di_read_rdy, frame_abort, wovf;
    logic [AW-1:0]          waddr, raddr;
    logic [AW:0]            rlen;
    logic [CW-1:0]          frames_dropped;

    int n_pass  = 0;
    int n_total = 0;
    logic [4:0] wq [$];

    di_pingpong_sched #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .drop_old       (drop_old),
        .dvi            (dvi),
        .dtypei         (dtypei),
        .di_read_mode   (di_read_mode),
        .di_read        (di_read),
        .we             (we),
        .wsel           (wsel),
        .waddr          (waddr),
        .wphase         (wphase),
        .rsel           (rsel),
        .raddr          (raddr),
        .di_read_rdy    (di_read_rdy),
        .rlen           (rlen),
        .frames_dropped (frames_dropped),
        .frame_abort    (frame_abort),
        .wovf           (wovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            check("we_pending", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0)
                check("we_bank_phase_addr", {27'd0, wsel, wphase, waddr}, {27'd0, wq.pop_front()});
        end
    end

    task automatic beat(input logic [DTYPE_WIDTH-1:0] t);
        dvi = 1'b1;
        dtypei = t;
        @(posedge clk);
        #1;
        dvi = 1'b0;
        dtypei = '0;
    endtask

    task automatic pixels(input int npix, input int bank, input bit expect_write);
        for (int i = 0; i < npix; i++) begin
            if (expect_write && (i % 2 == 1) && (i / 2 < (1 << AW)))
                wq.push_back({1'(bank), 1'b1, AW'(i / 2)});
            beat((i % 2 == 0) ? 4'h4 : 4'h8);
        end
    endtask

    task automatic send_frame(input int npix, input int bank, input bit expect_write);
        beat(c_DTYPE_FRAME_START);
        pixels(npix, bank, expect_write);
        if (expect_write && (npix % 2 == 1) && (npix / 2 < (1 << AW)))
            wq.push_back({1'(bank), 1'b1, AW'(npix / 2)});
        beat(c_DTYPE_FRAME_END);
    endtask

    task automatic wait_rdy();
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (di_read_rdy === 1'b1) break;
        end
        check("rd_wait_rdy", {31'd0, di_read_rdy}, 32'd1);
    endtask

    task automatic read_session(input int bank, input int len);
        di_read_mode = 1'b1;
        wait_rdy();
        check("rd_bank", {31'd0, rsel}, 32'(bank));
        check("rd_len", {28'd0, rlen}, 32'(len));
        for (int k = 0; k < len; k++) begin
            check("rd_addr", {29'd0, raddr}, 32'(k % (1 << AW)));
            check("rd_rdy_high", {31'd0, di_read_rdy}, 32'd1);
            di_read = 1'b1;
            @(negedge clk);
        end
        check("rd_rdy_after_last", {31'd0, di_read_rdy}, 32'd0);
        check("rd_addr_end", {29'd0, raddr}, 32'(len % (1 << AW)));
        @(negedge clk);
        check("rd_ignored_when_not_rdy", {29'd0, raddr}, 32'(len % (1 << AW)));
        di_read = 1'b0;
        di_read_mode = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;  enable = 1'b1;  drop_old = 1'b0;  dvi = 1'b0;
        dtypei = '0;   di_read_mode = 1'b0;  di_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_write_side", {26'd0, we, wsel, wphase, waddr}, 32'd0);
        check("reset_read_side", {23'd0, rsel, raddr, di_read_rdy, rlen}, 32'd0);
        check("reset_status", {14'd0, frames_dropped, frame_abort, wovf}, 32'd0);

        // Six pixels into bank 0 with the host already waiting.
        di_read_mode = 1'b1;
        send_frame(6, 0, 1);
        @(negedge clk);
        check("rdy_not_yet", {31'd0, di_read_rdy}, 32'd0);
        @(negedge clk);
        check("rdy_latency", {31'd0, di_read_rdy}, 32'd1);
        read_session(0, 3);

        // Odd pixel count flushes the half word on FRAME_END.
        send_frame(5, 0, 1);
        read_session(0, 3);

        // Buffer full, incoming frame dropped.
        send_frame(2, 0, 1);
        send_frame(4, 1, 1);
        send_frame(6, 0, 0);
        check("dropped_keep_old", 32'(frames_dropped), 32'd1);
        read_session(0, 1);
        read_session(1, 2);

        // Buffer full, oldest frame overwritten.
        drop_old = 1'b1;
        send_frame(2, 0, 1);
        send_frame(4, 1, 1);
        send_frame(6, 0, 1);
        check("dropped_overwrite", 32'(frames_dropped), 32'd2);
        read_session(1, 2);
        read_session(0, 3);
        drop_old = 1'b0;

        // Missing FRAME_END: restart capture in the same bank.
        beat(c_DTYPE_FRAME_START);
        pixels(4, 0, 1);
        beat(c_DTYPE_FRAME_START);
        check("abort_pulse", {31'd0, frame_abort}, 32'd1);
        pixels(2, 0, 1);
        check("abort_one_cycle", {31'd0, frame_abort}, 32'd0);
        beat(c_DTYPE_FRAME_END);
        read_session(0, 1);

        // Bank overflow, then reset in the middle of the read.
        check("wovf_clear_before", {31'd0, wovf}, 32'd0);
        send_frame(20, 0, 1);
        check("wovf_set", {31'd0, wovf}, 32'd1);
        di_read_mode = 1'b1;
        wait_rdy();
        check("ovf_len", {28'd0, rlen}, 32'd8);
        for (int k = 0; k < 3; k++) begin
            di_read = 1'b1;
            @(negedge clk);
        end
        di_read = 1'b0;
        check("partial_read_addr", {29'd0, raddr}, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_read_rdy", {31'd0, di_read_rdy}, 32'd0);
        check("reset_mid_read_regs", {22'd0, raddr, rlen, rsel, wovf, frame_abort}, 32'd0);
        check("reset_mid_read_dropped", 32'(frames_dropped), 32'd0);
        reset = 1'b0;
        di_read_mode = 1'b0;
        @(posedge clk);
        #1;

        // Both banks must be free again after the reset.
        send_frame(2, 0, 1);
        send_frame(2, 1, 1);
        check("post_reset_no_drop", 32'(frames_dropped), 32'd0);
        read_session(0, 1);
        read_session(1, 1);

        repeat (2) @(negedge clk);
        check("write_queue_drained", 32'(wq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
